// File: rtl/add_seq_pkg.sv
// Shared types for the add sequencer: FSM state encodings, glyph codes and
// the signed-value-to-display-pair helper.
package add_seq_pkg;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_CALC = 2'd2,
        S_SHOW = 2'd3
    } state_e;

    // Codes 0x00-0x0F are plain hex digits.
    typedef logic [4:0] glyph_t;

    localparam glyph_t G_BLANK = 5'h10;
    localparam glyph_t G_MINUS = 5'h11;
    localparam glyph_t G_O     = 5'h12;
    localparam glyph_t G_F     = 5'h13;

    typedef struct packed {
        glyph_t sign;
        glyph_t mag;
    } pair_t;

    localparam pair_t PAIR_BLANK = {G_BLANK, G_BLANK};

    // Two's-complement nibble to sign + magnitude; -8 negates to 4'b1000 = 8.
    function automatic pair_t value_pair(input logic [3:0] v);
        pair_t      p;
        logic [3:0] m;
        m      = v[3] ? (~v + 4'd1) : v;
        p.sign = v[3] ? G_MINUS : G_BLANK;
        p.mag  = {1'b0, m};
        return p;
    endfunction

endpackage

// File: rtl/glyph_decode.sv
// Glyph code to active-low seven-segment pattern {dp,g,f,e,d,c,b,a}.
module glyph_decode
    import add_seq_pkg::*;
(
    input  logic [4:0] glyph_i,
    output logic [7:0] seg_o
);

    logic [6:0] seg_on;

    always_comb begin
        seg_on = 7'h00;
        case (glyph_i)
            5'h00:   seg_on = 7'h3F;
            5'h01:   seg_on = 7'h06;
            5'h02:   seg_on = 7'h5B;
            5'h03:   seg_on = 7'h4F;
            5'h04:   seg_on = 7'h66;
            5'h05:   seg_on = 7'h6D;
            5'h06:   seg_on = 7'h7D;
            5'h07:   seg_on = 7'h07;
            5'h08:   seg_on = 7'h7F;
            5'h09:   seg_on = 7'h6F;
            5'h0A:   seg_on = 7'h77;
            5'h0B:   seg_on = 7'h7C;
            5'h0C:   seg_on = 7'h39;
            5'h0D:   seg_on = 7'h5E;
            5'h0E:   seg_on = 7'h79;
            5'h0F:   seg_on = 7'h71;
            G_MINUS: seg_on = 7'h40;
            G_O:     seg_on = 7'h3F;
            G_F:     seg_on = 7'h71;
            default: seg_on = 7'h00;
        endcase
    end

    assign seg_o = {1'b1, ~seg_on};

endmodule

// File: rtl/add_sequencer.sv
// Two-operand 4-bit signed adder driven by one debounced key, shown on six
// seven-segment digits. Define OVF_BLINK_EN to make the "OF" indication blink.
module add_sequencer
    import add_seq_pkg::*;
#(
    parameter int DB_COUNT     = 500000,
    parameter int BLINK_CYCLES = 25000000
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       key_n,
    output logic [7:0] HEX5,
    output logic [7:0] HEX4,
    output logic [7:0] HEX3,
    output logic [7:0] HEX2,
    output logic [7:0] HEX1,
    output logic [7:0] HEX0,
    output logic [1:0] state_o
);

    localparam int DB_W = $clog2(DB_COUNT + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_COUNT - 1);

    // The arming window must outlast the two reset-valued synchronizer samples.
    if (DB_COUNT < 3 || BLINK_CYCLES < 1) begin : g_param_check
        $error("add_sequencer: DB_COUNT must be >= 3 and BLINK_CYCLES >= 1");
    end

    logic            key_meta_q, key_sync_q;
    logic            db_level_q, db_level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            armed_q, armed_d;
    logic            level_prev_q;
    logic            press_q;

    // After reset the key must be seen released for DB_COUNT samples before
    // any press is accepted, so a key held through reset cannot fire.
    always_comb begin
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        armed_d    = armed_q;
        if (!armed_q) begin
            if (key_sync_q) begin
                if (db_cnt_q == DB_LAST) armed_d  = 1'b1;
                else                     db_cnt_d = db_cnt_q + 1'b1;
            end
        end else if (key_sync_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) db_level_d = key_sync_q;
            else                     db_cnt_d   = db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta_q   <= 1'b1;
            key_sync_q   <= 1'b1;
            db_level_q   <= 1'b1;
            db_cnt_q     <= '0;
            armed_q      <= 1'b0;
            level_prev_q <= 1'b1;
            press_q      <= 1'b0;
        end else begin
            key_meta_q   <= key_n;
            key_sync_q   <= key_meta_q;
            db_level_q   <= db_level_d;
            db_cnt_q     <= db_cnt_d;
            armed_q      <= armed_d;
            level_prev_q <= db_level_q;
            press_q      <= level_prev_q & ~db_level_q;
        end
    end

    state_e     state_q;
    logic [3:0] reg_a_q, reg_b_q, sum_q;
    logic       ovf_q;
    logic [3:0] sum_d;
    logic       ovf_d;

    assign sum_d = reg_a_q + reg_b_q;
    assign ovf_d = (reg_a_q[3] == reg_b_q[3]) && (sum_d[3] != reg_a_q[3]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_A;
            reg_a_q <= 4'd0;
            reg_b_q <= 4'd0;
            sum_q   <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_A: if (press_q) begin
                    reg_a_q <= sw;
                    state_q <= S_B;
                end
                S_B: if (press_q) begin
                    reg_b_q <= sw;
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    sum_q   <= sum_d;
                    ovf_q   <= ovf_d;
                    state_q <= S_SHOW;
                end
                S_SHOW: if (press_q) begin
                    reg_a_q <= 4'd0;
                    reg_b_q <= 4'd0;
                    sum_q   <= 4'd0;
                    ovf_q   <= 1'b0;
                    state_q <= S_A;
                end
                default: state_q <= S_A;
            endcase
        end
    end

    assign state_o = state_q;

    logic show_of;

`ifdef OVF_BLINK_EN
    localparam int BL_W = $clog2(BLINK_CYCLES + 1);
    logic [BL_W-1:0] blink_cnt_q;
    logic            blink_on_q;

    always_ff @(posedge clk) begin
        if (reset || state_q != S_SHOW) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (blink_cnt_q == BL_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_q <= '0;
            blink_on_q  <= ~blink_on_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    assign show_of = blink_on_q;
`else
    assign show_of = 1'b1;
`endif

    pair_t pair_54, pair_32, pair_10;

    always_comb begin
        pair_54 = value_pair((state_q == S_A) ? sw : reg_a_q);
        pair_32 = PAIR_BLANK;
        pair_10 = PAIR_BLANK;
        case (state_q)
            S_A:     pair_32 = PAIR_BLANK;
            S_B:     pair_32 = value_pair(sw);
            default: pair_32 = value_pair(reg_b_q);
        endcase
        if (state_q == S_SHOW) begin
            if (!ovf_q)       pair_10 = value_pair(sum_q);
            else if (show_of) pair_10 = {G_O, G_F};
        end
    end

    glyph_t     glyph_d [6];
    logic [7:0] seg_d   [6];
    logic [7:0] hex_q   [6];

    assign glyph_d[5] = pair_54.sign;
    assign glyph_d[4] = pair_54.mag;
    assign glyph_d[3] = pair_32.sign;
    assign glyph_d[2] = pair_32.mag;
    assign glyph_d[1] = pair_10.sign;
    assign glyph_d[0] = pair_10.mag;

    for (genvar g = 0; g < 6; g++) begin : g_digit
        glyph_decode u_glyph (
            .glyph_i (glyph_d[g]),
            .seg_o   (seg_d[g])
        );
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            hex_q[i] <= reset ? 8'hFF : seg_d[i];
        end
    end

    assign HEX5 = hex_q[5];
    assign HEX4 = hex_q[4];
    assign HEX3 = hex_q[3];
    assign HEX2 = hex_q[2];
    assign HEX1 = hex_q[1];
    assign HEX0 = hex_q[0];

endmodule

// File: tb/tb_add_sequencer.sv
// Scoreboard bench for add_sequencer: expected state transitions and display
// snapshots are queued by the stimulus and checked by an independent monitor.
module tb_add_sequencer;

    localparam int DB = 4;
    localparam int BL = 8;

    localparam logic [7:0] SG_BL = 8'hFF;
    localparam logic [7:0] SG_MI = 8'hBF;
    localparam logic [7:0] SG_0  = 8'hC0;
    localparam logic [7:0] SG_1  = 8'hF9;
    localparam logic [7:0] SG_2  = 8'hA4;
    localparam logic [7:0] SG_3  = 8'hB0;
    localparam logic [7:0] SG_5  = 8'h92;
    localparam logic [7:0] SG_7  = 8'hF8;
    localparam logic [7:0] SG_8  = 8'h80;
    localparam logic [7:0] SG_O  = 8'hC0;
    localparam logic [7:0] SG_F  = 8'h8E;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sw = 4'd0;
    logic       key_n = 1'b1;
    logic [7:0] hex5, hex4, hex3, hex2, hex1, hex0;
    logic [1:0] state_o;

    add_sequencer #(.DB_COUNT(DB), .BLINK_CYCLES(BL)) dut (
        .clk     (clk),
        .reset   (reset),
        .sw      (sw),
        .key_n   (key_n),
        .HEX5    (hex5),
        .HEX4    (hex4),
        .HEX3    (hex3),
        .HEX2    (hex2),
        .HEX1    (hex1),
        .HEX0    (hex0),
        .state_o (state_o)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;

    int unsigned cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Scoreboard state
    logic [49:0] exp_q[$];
    int unsigned exp_cyc_q[$];
    string       exp_name_q[$];
    logic [1:0]  st_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [1:0]  prev_st = 2'd0;

    task automatic check_field(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [1:0]  exp_s;
        logic [49:0] rec;
        int unsigned c;
        string       nm;
        if (mon_en && state_o !== prev_st) begin
            checks++;
            if (st_q.size() == 0) begin
                errors++;
                $display("FAIL state_seq: unexpected transition to %0d", state_o);
            end else begin
                exp_s = st_q.pop_front();
                if (state_o !== exp_s) begin
                    errors++;
                    $display("FAIL state_seq: got %0d expected %0d", state_o, exp_s);
                end
            end
        end
        prev_st = state_o;
        if (exp_q.size() > 0 && exp_cyc_q[0] <= cycle) begin
            rec = exp_q.pop_front();
            c   = exp_cyc_q.pop_front();
            nm  = exp_name_q.pop_front();
            if (c != cycle) begin
                checks++;
                errors++;
                $display("FAIL %s.timing: sampled at cycle %0d expected %0d", nm, cycle, c);
            end
            check_field({nm, ".state"}, {6'd0, state_o}, {6'd0, rec[49:48]});
            check_field({nm, ".hex5"}, hex5, rec[47:40]);
            check_field({nm, ".hex4"}, hex4, rec[39:32]);
            check_field({nm, ".hex3"}, hex3, rec[31:24]);
            check_field({nm, ".hex2"}, hex2, rec[23:16]);
            check_field({nm, ".hex1"}, hex1, rec[15:8]);
            check_field({nm, ".hex0"}, hex0, rec[7:0]);
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_snap(input string name, input logic [1:0] st,
                               input logic [7:0] h5, input logic [7:0] h4,
                               input logic [7:0] h3, input logic [7:0] h2,
                               input logic [7:0] h1, input logic [7:0] h0);
        exp_q.push_back({st, h5, h4, h3, h2, h1, h0});
        exp_cyc_q.push_back(cycle);
        exp_name_q.push_back(name);
    endtask

    task automatic press(input bit bouncy);
        if (bouncy) begin
            key_n = 1'b0; tick(2);
            key_n = 1'b1; tick(1);
        end
        key_n = 1'b0; tick(10);
        key_n = 1'b1; tick(12);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        int n;
        n = 0;
        while (state_o !== s && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (state_o !== s) begin
            errors++;
            $display("FAIL wait_state: got %0d expected %0d within %0d cycles", state_o, s, budget);
        end
    endtask

    // Press that lands in S_SHOW with an overflow; checks the blink phases.
    task automatic press_to_ovf(input string name, input logic [7:0] h5, input logic [7:0] h4,
                                input logic [7:0] h3, input logic [7:0] h2);
        key_n = 1'b0;
        wait_state(2'd3, 30);
        tick(4);
        expect_snap({name, "_on"}, 3, h5, h4, h3, h2, SG_O, SG_F);
        tick(8);
`ifdef OVF_BLINK_EN
        expect_snap({name, "_blank"}, 3, h5, h4, h3, h2, SG_BL, SG_BL);
`else
        expect_snap({name, "_steady"}, 3, h5, h4, h3, h2, SG_O, SG_F);
`endif
        tick(8);
        expect_snap({name, "_back"}, 3, h5, h4, h3, h2, SG_O, SG_F);
        key_n = 1'b1;
        tick(12);
    endtask

    // Stimulus
    initial begin
        reset = 1'b1;
        tick(3);
        expect_snap("reset", 0, SG_BL, SG_BL, SG_BL, SG_BL, SG_BL, SG_BL);
        tick(1);
        reset = 1'b0;
        tick(12);
        mon_en = 1'b1;

        sw = 4'b0011; tick(2);
        expect_snap("a_live3", 0, SG_BL, SG_3, SG_BL, SG_BL, SG_BL, SG_BL);

        st_q.push_back(1);
        press(1'b1);
        sw = 4'b1110; tick(2);
        expect_snap("a_latched", 1, SG_BL, SG_3, SG_MI, SG_2, SG_BL, SG_BL);

        st_q.push_back(2); st_q.push_back(3);
        press(1'b0);
        sw = 4'b0111; tick(2);
        expect_snap("sum_3_m2", 3, SG_BL, SG_3, SG_MI, SG_2, SG_BL, SG_1);

        st_q.push_back(0);
        press(1'b0); tick(2);
        expect_snap("a_live7", 0, SG_BL, SG_7, SG_BL, SG_BL, SG_BL, SG_BL);

        st_q.push_back(1);
        press(1'b0);
        sw = 4'b0001; tick(2);
        expect_snap("b_live1", 1, SG_BL, SG_7, SG_BL, SG_1, SG_BL, SG_BL);

        st_q.push_back(2); st_q.push_back(3);
        press_to_ovf("of_7_1", SG_BL, SG_7, SG_BL, SG_1);

        st_q.push_back(0);
        sw = 4'b1000;
        press(1'b0); tick(2);
        expect_snap("a_live_m8", 0, SG_MI, SG_8, SG_BL, SG_BL, SG_BL, SG_BL);

        st_q.push_back(1);
        press(1'b0);
        st_q.push_back(2); st_q.push_back(3);
        press_to_ovf("of_m8_m8", SG_MI, SG_8, SG_MI, SG_8);

        st_q.push_back(0);
        sw = 4'b0000;
        press(1'b0); tick(2);
        expect_snap("cleared", 0, SG_BL, SG_0, SG_BL, SG_BL, SG_BL, SG_BL);

        st_q.push_back(1);
        sw = 4'b0101;
        press(1'b0); tick(2);
        expect_snap("b_entry", 1, SG_BL, SG_5, SG_BL, SG_5, SG_BL, SG_BL);

        // Reset lands on the same edge the press pulse would advance S_B.
        st_q.push_back(0);
        key_n = 1'b0; tick(7);
        reset = 1'b1; tick(1);
        expect_snap("reset_in_b", 0, SG_BL, SG_BL, SG_BL, SG_BL, SG_BL, SG_BL);
        tick(1);
        reset = 1'b0; tick(15);
        key_n = 1'b1; tick(20);
        expect_snap("after_reset", 0, SG_BL, SG_5, SG_BL, SG_BL, SG_BL, SG_BL);

        st_q.push_back(1);
        sw = 4'b0010;
        press(1'b0); tick(2);
        expect_snap("resume", 1, SG_BL, SG_2, SG_BL, SG_2, SG_BL, SG_BL);

        tick(5);
        checks++;
        if (st_q.size() != 0) begin
            errors++;
            $display("FAIL state_seq_left: got %0d pending expected 0", st_q.size());
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL snap_left: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_sequencer.md
ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 SHALL have parameter DB_COUNT, default 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz).
REQ-002 SHALL have parameter BLINK_CYCLES, default 25000000, half-period of the overflow blink, used only when OVF_BLINK_EN is defined.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sw  input  4  operand entry, two's complement (-8..+7).
REQ-006 key_n  input  1  enter pushbutton, active-low, asynchronous to clk, bouncing.
REQ-007 HEX5, HEX4, HEX3, HEX2, HEX1, HEX0  output  8 each  active-low segments {dp,g,f,e,d,c,b,a}; dp is always 1.
REQ-008 state_o  output  2  current FSM state encoding, for LEDs.

Function
REQ-009 key_n SHALL pass a 2-FF synchronizer, then a debouncer that accepts a new level only after DB_COUNT consecutive identical samples.
REQ-010 A debounced high-to-low transition SHALL produce exactly one single-cycle press pulse; no further pulse until a debounced release has occurred.
REQ-011 FSM states: S_A=0, S_B=1, S_CALC=2, S_SHOW=3.
REQ-012 S_A: press latches sw into reg_a, next state S_B.
REQ-013 S_B: press latches sw into reg_b, next state S_CALC.
REQ-014 S_CALC: unconditionally for one cycle; sum = reg_a + reg_b, 4-bit wrap; ovf = (a[3]==b[3]) && (sum[3]!=a[3]); next state S_SHOW.
REQ-015 S_SHOW: holds reg_a, reg_b, sum, ovf; press clears all four registers, next state S_A.
REQ-016 A press pulse in S_CALC SHALL be ignored.
REQ-017 Each value pair SHALL display as sign digit (minus if negative, else blank) plus magnitude digit 0..8; -8 shows "-8".
REQ-018 HEX5/HEX4 SHALL show live sw in S_A and reg_a otherwise.
REQ-019 HEX3/HEX2 SHALL be blank in S_A, show live sw in S_B, and show reg_b otherwise.
REQ-020 HEX1/HEX0 SHALL be blank except in S_SHOW, where they show sum, or "OF" when ovf=1.
REQ-021 HEX outputs SHALL be registered: one cycle from sw or state change to HEX update.
REQ-022 State advances on the cycle after the press pulse; press pulse lags the settled key by DB_COUNT+3 cycles.

Reset
REQ-023 reset SHALL take priority over every other event, including a coincident press.
REQ-024 While reset is high: state S_A, reg_a=reg_b=sum=0, ovf=0, debouncer level=released, counters 0, all HEX=8'hFF, state_o=0.
REQ-025 Reset asserted mid-operation (any state) SHALL abort to the reset values above with no press pulse generated on release.

Configuration
REQ-026 With OVF_BLINK_EN defined, "OF" on HEX1/HEX0 SHALL alternate visible/blank every BLINK_CYCLES cycles, starting visible on entry to S_SHOW.
REQ-027 Without OVF_BLINK_EN, "OF" SHALL be steady and the blink counter SHALL not exist.

Structure
REQ-028 Shared package add_seq_pkg SHALL hold the state encodings and the 5-bit glyph codes (0x00-0x0F hex, 0x10 blank, 0x11 minus, 0x12 O, 0x13 F).
REQ-029 One sub-module, glyph_decode (5-bit glyph code to 8-bit active-low segments), SHALL be instantiated six times.

Verification (DB_COUNT=4, BLINK_CYCLES=8)
REQ-030 Reset, then sw=4'b0011 -> HEX5=FF, HEX4 shows "3", HEX3..HEX0=FF, state_o=0.
REQ-031 Bouncy press (low 2 cycles, high 1, then low 10) -> exactly one pulse; reg_a=3, state_o=1.
REQ-032 A=3, B=4'b1110 (-2) -> S_SHOW: HEX1 blank, HEX0 "1", ovf=0.
REQ-033 A=7, B=1 -> ovf=1, HEX1/HEX0 "OF"; with OVF_BLINK_EN, blank after 8 cycles, visible after 16.
REQ-034 A=-8, B=-8 -> HEX5/HEX4 "-8", HEX3/HEX2 "-8", "OF"; next press -> state_o=0, all registers cleared.
REQ-035 Reset asserted in S_B coincident with a press pulse -> S_A, reg_a=0, no state advance after reset deasserts.
